// File: rtl/apb_req_bridge_if.sv
// APB_BUS: APB3 bus bundle shared between a master and its slave decoder.
//   paddr, pwdata, pwrite, psel, penable : master -> slave
//   prdata, pready, pslverr              : slave -> master
interface APB_BUS #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32
);
  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic [APB_DATA_WIDTH-1:0] pwdata;
  logic                      pwrite;
  logic                      psel;
  logic                      penable;
  logic [APB_DATA_WIDTH-1:0] prdata;
  logic                      pready;
  logic                      pslverr;

  modport Master (
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport Slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_req_bridge.sv
// apb_req_bridge: turns a core-side req/gnt/rvalid data port into APB3 master
// transfers, one at a time. Addresses outside the peripheral window (or
// misaligned / partial-width writes) are answered with an error without any
// bus activity. A slave that holds pready low for TIMEOUT ACCESS cycles is
// abandoned and answered with err=1, rdata=32'hDEAD_BEEF.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   req_i / gnt_o       : request valid / grant (combinational, IDLE only)
//   addr_i, we_i, be_i,
//   wdata_i             : request payload, sampled on grant
//   rvalid_o            : one-cycle response strobe, one per grant
//   rdata_o, err_o      : response data/error, zero while rvalid_o is low
//   apb                 : APB3 master side of the peripheral bus
module apb_req_bridge #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter logic [31:0] WIN_START      = 32'h1A10_0000,
  parameter logic [31:0] WIN_END        = 32'h1A11_7FFF,
  parameter int unsigned TIMEOUT        = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  APB_BUS.Master      apb
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Counter value on the last permitted ACCESS cycle; unused when TIMEOUT=0.
  localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT - 1);
  localparam logic        LP_TO_EN    = (TIMEOUT != 0);
  localparam logic [31:0] LP_TO_DATA  = 32'hDEAD_BEEF;

  logic [1:0]                r_state;
  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic [APB_DATA_WIDTH-1:0] r_pwdata;
  logic                      r_pwrite;
  logic [31:0]               r_rdata;
  logic                      r_err;
  logic [15:0]               r_cnt;

  logic w_in_win;
  logic w_legal;
  logic w_expired;

  assign w_in_win  = (addr_i >= WIN_START) && (addr_i <= WIN_END);
  // Reads ignore be_i; writes must be full-word.
  assign w_legal   = w_in_win && (addr_i[1:0] == 2'b00) && (!we_i || (be_i == 4'hF));
  assign w_expired = LP_TO_EN && (r_cnt == LP_CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pwrite <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_i) begin
            r_paddr  <= APB_ADDR_WIDTH'(addr_i);
            r_pwdata <= APB_DATA_WIDTH'(wdata_i);
            r_pwrite <= we_i;
            if (w_legal) begin
              r_state <= ST_SETUP;
            end else begin
              // Rejected locally: psel never rises for this request.
              r_rdata <= '0;
              r_err   <= 1'b1;
              r_state <= ST_RESP;
            end
          end
        end
        ST_SETUP: begin
          r_cnt   <= '0;
          r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // pready takes priority over a timeout expiring in the same cycle.
          if (apb.pready) begin
            r_rdata <= r_pwrite ? 32'h0 : 32'(apb.prdata);
            r_err   <= apb.pslverr;
            r_state <= ST_RESP;
          end else if (w_expired) begin
            r_rdata <= LP_TO_DATA;
            r_err   <= 1'b1;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Bus strobes and handshake outputs decode straight from the state register
  // so that an asynchronous reset clears them immediately.
  assign gnt_o       = req_i && (r_state == ST_IDLE);
  assign rvalid_o    = (r_state == ST_RESP);
  assign rdata_o     = rvalid_o ? r_rdata : 32'h0;
  assign err_o       = rvalid_o && r_err;

  assign apb.psel    = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
  assign apb.penable = (r_state == ST_ACCESS);
  assign apb.paddr   = r_paddr;
  assign apb.pwdata  = r_pwdata;
  assign apb.pwrite  = r_pwrite;

endmodule

// File: tb/tb_apb_req_bridge.sv
module tb_apb_req_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0;
  logic        gnt_o;
  logic [31:0] addr_i = '0;
  logic        we_i = 1'b0;
  logic [3:0]  be_i = '0;
  logic [31:0] wdata_i = '0;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  APB_BUS #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32)) apb ();

  apb_req_bridge #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .WIN_START     (32'h1A10_0000),
    .WIN_END       (32'h1A11_7FFF),
    .TIMEOUT       (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req_i),
    .gnt_o   (gnt_o),
    .addr_i  (addr_i),
    .we_i    (we_i),
    .be_i    (be_i),
    .wdata_i (wdata_i),
    .rvalid_o(rvalid_o),
    .rdata_o (rdata_o),
    .err_o   (err_o),
    .apb     (apb)
  );

  always #5 clk = ~clk;

  int num_checks = 0;
  int num_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Slave model: pready after slv_waits wait states; slv_waits<0 never ready.
  int          slv_waits = 0;
  logic        slv_slverr = 1'b0;
  logic [31:0] slv_rdata = '0;
  int          acc_cycles = 0;

  always @(posedge clk) begin
    if (apb.psel && apb.penable && !apb.pready) acc_cycles <= acc_cycles + 1;
    else acc_cycles <= 0;
  end

  assign apb.pready  = apb.psel && apb.penable && (slv_waits >= 0) && (acc_cycles >= slv_waits);
  assign apb.prdata  = slv_rdata;
  assign apb.pslverr = slv_slverr && apb.pready;

  // Scoreboard
  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          at_cyc;
  } exp_t;

  exp_t sb_q[$];

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (rvalid_o) begin
        if (sb_q.size() == 0) begin
          check_val("unexpected_rvalid", 32'(rvalid_o), 32'h0);
        end else begin
          e = sb_q.pop_front();
          check_val("rdata", rdata_o, e.rd);
          check_val("err", 32'(err_o), 32'(e.err));
          check_val("rvalid_cycle", 32'(cyc), 32'(e.at_cyc));
          $display("resp: rdata=%h err=%0d at cycle %0d", rdata_o, err_o, cyc);
        end
      end else begin
        check_val("idle_rdata", rdata_o, 32'h0);
        check_val("idle_err", 32'(err_o), 32'h0);
      end
    end
  end

  // One request; lat = grant-to-rvalid cycles; bus shape checked every cycle.
  task automatic run_xfer(input string name, input logic [31:0] a, input logic w,
                          input logic [3:0] be, input logic [31:0] wd, input int waits,
                          input logic serr, input logic [31:0] srd,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input int lat, input logic legal);
    exp_t e;
    slv_waits  = waits;
    slv_slverr = serr;
    slv_rdata  = srd;
    @(negedge clk);
    req_i = 1'b1; addr_i = a; we_i = w; be_i = be; wdata_i = wd;
    #1;
    check_val({name, "_gnt"}, 32'(gnt_o), 32'h1);
    if (gnt_o) begin
      e.rd = exp_rd; e.err = exp_err; e.at_cyc = cyc + lat;
      sb_q.push_back(e);
    end
    $display("req %s: addr=%h we=%0d be=%h wdata=%h at cycle %0d", name, a, w, be, wd, cyc);
    @(posedge clk);
    #1;
    check_val({name, "_gnt_busy"}, 32'(gnt_o), 32'h0);
    req_i = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (legal && (c < lat)) begin
        check_val({name, "_psel"}, 32'(apb.psel), 32'h1);
        check_val({name, "_penable"}, 32'(apb.penable), 32'(c >= 2));
        check_val({name, "_pwrite"}, 32'(apb.pwrite), 32'(w));
        check_val({name, "_paddr"}, apb.paddr, a);
        if (w) check_val({name, "_pwdata"}, apb.pwdata, wd);
      end else begin
        check_val({name, "_psel_low"}, 32'(apb.psel), 32'h0);
        check_val({name, "_penable_low"}, 32'(apb.penable), 32'h0);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check_val("rst_psel", 32'(apb.psel), 32'h0);
    check_val("rst_penable", 32'(apb.penable), 32'h0);
    check_val("rst_pwrite", 32'(apb.pwrite), 32'h0);
    check_val("rst_paddr", apb.paddr, 32'h0);
    check_val("rst_pwdata", apb.pwdata, 32'h0);
    check_val("rst_rvalid", 32'(rvalid_o), 32'h0);
    check_val("rst_rdata", rdata_o, 32'h0);
    check_val("rst_err", 32'(err_o), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    //        name       addr          we    be     wdata          waits serr srd            exp_rd         err  lat legal
    run_xfer("rd0",     32'h1A10_1000, 1'b0, 4'h0, 32'h0,          0,  1'b0, 32'h1234_5678, 32'h1234_5678, 1'b0, 3, 1'b1);
    run_xfer("wr3",     32'h1A10_7004, 1'b1, 4'hF, 32'hCAFE_F00D,  3,  1'b0, 32'hFFFF_FFFF, 32'h0,         1'b0, 6, 1'b1);
    run_xfer("bad_win", 32'h2000_0000, 1'b0, 4'hF, 32'h0,          0,  1'b0, 32'h5555_5555, 32'h0,         1'b1, 1, 1'b0);
    run_xfer("bad_aln", 32'h1A10_0002, 1'b1, 4'hF, 32'h1111_2222,  0,  1'b0, 32'h0,         32'h0,         1'b1, 1, 1'b0);
    run_xfer("bad_be",  32'h1A10_0010, 1'b1, 4'h3, 32'h3333_4444,  0,  1'b0, 32'h0,         32'h0,         1'b1, 1, 1'b0);
    run_xfer("slverr",  32'h1A10_2000, 1'b0, 4'h0, 32'h0,          1,  1'b1, 32'hA5A5_0001, 32'hA5A5_0001, 1'b1, 4, 1'b1);
    run_xfer("tmo",     32'h1A10_3000, 1'b0, 4'h0, 32'h0,         -1,  1'b0, 32'h7777_7777, 32'hDEAD_BEEF, 1'b1, 6, 1'b1);
    run_xfer("tmo_rdy", 32'h1A10_3004, 1'b0, 4'h0, 32'h0,          3,  1'b0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 6, 1'b1);
    run_xfer("win_lo",  32'h1A10_0000, 1'b0, 4'h0, 32'h0,          0,  1'b0, 32'h0000_0001, 32'h0000_0001, 1'b0, 3, 1'b1);
    run_xfer("win_hi",  32'h1A11_7FFC, 1'b1, 4'hF, 32'h89AB_CDEF,  0,  1'b0, 32'h0,         32'h0,         1'b0, 3, 1'b1);
    run_xfer("above",   32'h1A11_8000, 1'b0, 4'h0, 32'h0,          0,  1'b0, 32'h0,         32'h0,         1'b1, 1, 1'b0);
    run_xfer("below",   32'h1A0F_FFFC, 1'b0, 4'h0, 32'h0,          0,  1'b0, 32'h0,         32'h0,         1'b1, 1, 1'b0);

    // Reset pulsed during ACCESS: bus clears at once, no response appears.
    slv_waits = -1; slv_slverr = 1'b0; slv_rdata = 32'h0;
    @(negedge clk);
    req_i = 1'b1; addr_i = 32'h1A10_4000; we_i = 1'b1; be_i = 4'hF; wdata_i = 32'h1357_9BDF;
    @(posedge clk);
    #1;
    req_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("pre_rst_penable", 32'(apb.penable), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_val("async_psel", 32'(apb.psel), 32'h0);
    check_val("async_penable", 32'(apb.penable), 32'h0);
    check_val("async_rvalid", 32'(rvalid_o), 32'h0);
    check_val("async_paddr", apb.paddr, 32'h0);
    $display("reset pulsed during ACCESS at cycle %0d", cyc);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    run_xfer("post_rst", 32'h1A10_4000, 1'b0, 4'h0, 32'h0, 0, 1'b0, 32'h2468_ACE0, 32'h2468_ACE0, 1'b0, 3, 1'b1);

    repeat (4) @(negedge clk);
    check_val("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
